pm_ctrl: RTL
============

# pm_ctrl

Memory-mapped controller for the pattern-matching peripheral, sitting behind the `biu` as a third data-bus slave next to `dmem` and `outperiph`. The CPU loads a pattern and a text buffer byte-by-byte, writes START, and `pm_ctrl` sequences a byte-serial sliding-window comparison. It then reports the match count and first-match index through read registers. Its read data is returned to the `biu` as `drdata3`.

## Interface
- `PAT_MAX`, default 8: pattern buffer depth in bytes.
- `TXT_MAX`, default 64: text buffer depth in bytes.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sel` in 1: `biu` decode, high when `daddr` targets this peripheral.
- `daddr` in 32: byte address; only `daddr[4:2]` is decoded.
- `dwdata` in 32: write data; byte registers use `[7:0]`.
- `dwe` in 4: write enables; any nonzero value with `sel` high is a write.
- `drdata` out 32: combinational read data for the current `daddr`; 0 when `sel` is low.
- `busy` out 1: high while a scan is running.
- `done` out 1: sticky scan-complete flag.

## Operation
- Register map, by word offset:
  - 0x00 CTRL (W): bit0 START, bit1 CLEAR.
  - 0x04 STATUS (R): bit0 busy, bit1 done, bit2 found, bit3 err, bit4 ovf.
  - 0x08 PLEN (R/W): `[3:0]`.
  - 0x0C TLEN (R/W): `[6:0]`.
  - 0x10 PDATA (W): pushes a byte at `pwp`, then `pwp++`.
  - 0x14 TDATA (W): pushes a byte at `twp`, then `twp++`.
  - 0x18 COUNT (R): match count, zero-extended.
  - 0x1C FIRST (R): index of first match; `0xFFFF_FFFF` if none.
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on START write with valid lengths.
  - IDLE→DONE on START write with invalid lengths.
  - SCAN→DONE after the last compare.
  - DONE→IDLE on the next cycle.
- Lengths are valid when 1 ≤ PLEN ≤ PAT_MAX, 1 ≤ TLEN ≤ TXT_MAX, and PLEN ≤ TLEN.
  - An invalid start sets err, count=0, FIRST=all-ones.
- Scan: window index i runs 0..TLEN−PLEN; byte index j runs 0..PLEN−1. One byte compare per cycle; no early exit.
  - At the end of each window, a window with all bytes equal increments COUNT.
  - The first matching window latches i into FIRST and sets found.
  - Windows may overlap.
- START while busy: ignored.
- PLEN, TLEN, PDATA, TDATA and CLEAR writes while busy: ignored.
- PDATA/TDATA push when the pointer is already at PAT_MAX/TXT_MAX: byte dropped, pointer holds, ovf set.
- CLEAR (idle only): zeroes `pwp`, `twp`, COUNT; clears done, found, err, ovf; sets FIRST to all-ones. Buffer contents are retained.
- START (accepted): clears done, found, err and COUNT, and sets FIRST to all-ones, at the same edge.
- Reset values:
  - state IDLE, busy=0, done=0.
  - PLEN=0, TLEN=0, `pwp`=`twp`=0, COUNT=0, FIRST=all-ones.
  - found=err=ovf=0.
  - Buffer contents are don't-care.

## Timing
- Writes take effect at the rising edge where `sel` and `dwe≠0` are both high. Reads are combinational, same cycle.
- START accepted at edge k:
  - busy=1 from k to k+N, where N=(TLEN−PLEN+1)·PLEN.
  - COUNT, FIRST and found are final, and done=1, at edge k+N.
- Invalid START at edge k: done=1 and err=1 after edge k+1; busy stays 0.
- `busy` is 1 exactly in SCAN.
- `done` stays set until the next accepted START, a CLEAR, or reset.
- Reset asserted mid-SCAN aborts the scan: all outputs return to reset values at that edge, and no partial COUNT remains.
- COUNT width is 7 bits. The maximum is TXT_MAX, so no wrap is possible.

## Structure
- Shared package `pm_pkg`:
  - register offset localparams;
  - state enum (IDLE/SCAN/DONE);
  - STATUS bit positions;
  - FIRST none-value `32'hFFFF_FFFF`.
- Sub-module `pm_bytebuf` (parameter DEPTH), instantiated twice:
  - synchronous write port;
  - asynchronous read port;
  - write pointer with saturating increment and overflow flag.
- `pm_ctrl` holds the register decode, FSM, i/j counters, the per-window match accumulator, and the COUNT/FIRST logic.

## Test plan
- Basic match:
  - Stimulus: PLEN=2, PDATA 0x61,0x62; TLEN=5, TDATA "abcab"; START.
  - Response: busy for 8 cycles; then COUNT=2, FIRST=0, STATUS=0x06.
- Overlap:
  - Stimulus: pattern "aa", text "aaaa".
  - Response: N=6; COUNT=3, FIRST=0.
- No match:
  - Stimulus: pattern "xy", text "abcd".
  - Response: COUNT=0, FIRST=0xFFFF_FFFF, found=0, done=1.
- Invalid length and busy writes:
  - Stimulus A: PLEN=3, TLEN=2, START. Response: done and err one cycle later, busy never 1.
  - Stimulus B: during a valid scan, write TDATA and START. Response: both ignored; results unchanged.
- Overflow:
  - Stimulus: 9 PDATA writes with PAT_MAX=8.
  - Response: ovf=1, 9th byte dropped. CLEAR clears ovf and pointers.
- Reset mid-scan:
  - Stimulus: assert reset 3 cycles into an 8-cycle scan.
  - Response: busy=0, COUNT=0, FIRST=all-ones, done=0. A following reload and START completes correctly.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared definitions for the pattern-matching peripheral: register map,
// controller states, STATUS bit layout and the "no match" FIRST value.
package pm_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_PLEN   = 3'd2;
    localparam logic [2:0] REG_TLEN   = 3'd3;
    localparam logic [2:0] REG_PDATA  = 3'd4;
    localparam logic [2:0] REG_TDATA  = 3'd5;
    localparam logic [2:0] REG_COUNT  = 3'd6;
    localparam logic [2:0] REG_FIRST  = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_FOUND = 2;
    localparam int STAT_ERR   = 3;
    localparam int STAT_OVF   = 4;

    localparam logic [31:0] FIRST_NONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } pm_state_t;

endpackage

// File: rtl/pm_bytebuf.sv
// Byte buffer with a saturating write pointer. Pushes past the end are
// dropped and flagged; reads are asynchronous so the scanner can compare
// one byte per cycle without extra latency.
module pm_bytebuf #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    output logic          ovf
);

    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp;
    logic          full;

    assign full  = (wp == FULL);
    assign rdata = mem[raddr];

    // Storage array: contents survive reset and clear, only pushes change them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wp[AW-1:0]] <= wdata;
        end
    end

    // Write pointer and overflow flag; a full buffer holds its pointer and records the drop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wp  <= '0;
            ovf <= 1'b0;
        end else if (push) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                wp <= wp + PW'(1);
            end
        end
    end

endmodule

// File: rtl/pm_ctrl.sv
// Memory-mapped pattern-matching controller. The CPU fills the pattern and
// text buffers, writes START, and a byte-serial sliding-window scan counts
// matching windows and records the first matching offset.
module pm_ctrl
    import pm_pkg::*;
#(
    parameter int PAT_MAX = 8,
    parameter int TXT_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        busy,
    output logic        done
);

    localparam int PAW = $clog2(PAT_MAX);
    localparam int TAW = $clog2(TXT_MAX);
    localparam logic [3:0] PMAX = 4'(PAT_MAX);
    localparam logic [6:0] TMAX = 7'(TXT_MAX);

    pm_state_t   state;
    logic [3:0]  plen;
    logic [6:0]  tlen;
    logic [6:0]  count;
    logic [31:0] first;
    logic        found;
    logic        err;
    logic [6:0]  wi;
    logic [3:0]  wj;
    logic        acc;

    logic [2:0]  woff;
    logic        wr;
    logic        not_scan;
    logic        do_start;
    logic        do_clear;
    logic        pbuf_push;
    logic        tbuf_push;
    logic        len_ok;
    logic [6:0]  last_i;
    logic [3:0]  last_j;
    logic [6:0]  tidx;
    logic [7:0]  pbyte;
    logic [7:0]  tbyte;
    logic        byte_eq;
    logic        win_hit;
    logic        pbuf_ovf;
    logic        tbuf_ovf;
    logic        unused_bits;

    assign woff      = daddr[4:2];
    assign wr        = sel && (dwe != 4'b0000);
    assign not_scan  = (state != ST_SCAN);
    assign do_start  = wr && (woff == REG_CTRL) && dwdata[CTRL_START] && (state == ST_IDLE);
    assign do_clear  = wr && (woff == REG_CTRL) && dwdata[CTRL_CLEAR] && (state == ST_IDLE);
    assign pbuf_push = wr && (woff == REG_PDATA) && not_scan;
    assign tbuf_push = wr && (woff == REG_TDATA) && not_scan;

    assign len_ok = (plen != 4'd0) && (plen <= PMAX) &&
                    (tlen != 7'd0) && (tlen <= TMAX) &&
                    ({3'b000, plen} <= tlen);

    assign last_i  = tlen - {3'b000, plen};
    assign last_j  = plen - 4'd1;
    assign tidx    = wi + {3'b000, wj};
    assign byte_eq = (pbyte == tbyte);
    assign win_hit = acc && byte_eq;

    assign unused_bits = &{1'b0, daddr[31:5], daddr[1:0], dwdata[31:8], tidx[6]};

    pm_bytebuf #(.DEPTH(PAT_MAX)) u_pbuf (
        .clk   (clk),
        .reset (reset),
        .clear (do_clear),
        .push  (pbuf_push),
        .wdata (dwdata[7:0]),
        .raddr (wj[PAW-1:0]),
        .rdata (pbyte),
        .ovf   (pbuf_ovf)
    );

    pm_bytebuf #(.DEPTH(TXT_MAX)) u_tbuf (
        .clk   (clk),
        .reset (reset),
        .clear (do_clear),
        .push  (tbuf_push),
        .wdata (dwdata[7:0]),
        .raddr (tidx[TAW-1:0]),
        .rdata (tbyte),
        .ovf   (tbuf_ovf)
    );

    // Controller FSM: register writes, scan sequencing and result registers in one place.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            err   <= 1'b0;
            plen  <= 4'd0;
            tlen  <= 7'd0;
            count <= 7'd0;
            first <= FIRST_NONE;
            wi    <= 7'd0;
            wj    <= 4'd0;
            acc   <= 1'b0;
        end else begin
            if (wr && not_scan && (woff == REG_PLEN)) begin
                plen <= dwdata[3:0];
            end
            if (wr && not_scan && (woff == REG_TLEN)) begin
                tlen <= dwdata[6:0];
            end
            case (state)
                ST_IDLE: begin
                    if (do_clear) begin
                        count <= 7'd0;
                        first <= FIRST_NONE;
                        done  <= 1'b0;
                        found <= 1'b0;
                        err   <= 1'b0;
                    end
                    if (do_start) begin
                        count <= 7'd0;
                        first <= FIRST_NONE;
                        done  <= 1'b0;
                        found <= 1'b0;
                        wi    <= 7'd0;
                        wj    <= 4'd0;
                        acc   <= 1'b1;
                        if (len_ok) begin
                            state <= ST_SCAN;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (wj == last_j) begin
                        wj  <= 4'd0;
                        acc <= 1'b1;
                        if (win_hit) begin
                            count <= count + 7'd1;
                            if (!found) begin
                                first <= {25'd0, wi};
                                found <= 1'b1;
                            end
                        end
                        if (wi == last_i) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            wi <= wi + 7'd1;
                        end
                    end else begin
                        wj  <= wj + 4'd1;
                        acc <= win_hit;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: combinational register read, quiet when the peripheral is not selected.
    always_comb begin
        drdata = 32'd0;
        if (sel) begin
            case (woff)
                REG_STATUS: begin
                    drdata[STAT_BUSY]  = busy;
                    drdata[STAT_DONE]  = done;
                    drdata[STAT_FOUND] = found;
                    drdata[STAT_ERR]   = err;
                    drdata[STAT_OVF]   = pbuf_ovf | tbuf_ovf;
                end
                REG_PLEN:  drdata = {28'd0, plen};
                REG_TLEN:  drdata = {25'd0, tlen};
                REG_COUNT: drdata = {25'd0, count};
                REG_FIRST: drdata = first;
                default:   drdata = 32'd0;
            endcase
        end
    end

endmodule
